// File: rtl/systolic_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_stream: ROWS x COLS weight-stationary signed MAC array, handshaked
// streams, double-buffered weights.                               Rev 1.0
// ---------------------------------------------------------------------------
module systolic_stream #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int ACC_W  = 2*DATA_W+$clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [COLS*DATA_W-1:0]  w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [ROWS*DATA_W-1:0]  x_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [COLS*ACC_W-1:0]   y_data
);
  localparam int LAT    = ROWS + COLS;
  localparam int PROD_W = 2*DATA_W;
  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int INF_W  = $clog2(LAT + 2);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PENDING = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic signed [DATA_W-1:0] r_wact  [ROWS][COLS];
  logic signed [DATA_W-1:0] r_wsh   [ROWS][COLS];
  logic signed [DATA_W-1:0] r_skew  [ROWS][ROWS];
  logic signed [DATA_W-1:0] w_x     [ROWS];
  logic signed [DATA_W-1:0] w_wbeat [COLS];
  logic signed [DATA_W-1:0] w_ain   [ROWS][COLS];
  logic signed [DATA_W-1:0] r_act   [ROWS][COLS];
  logic signed [PROD_W-1:0] w_prod  [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_pin   [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_mac   [ROWS][COLS];
  logic signed [ACC_W-1:0]  r_psum  [ROWS][COLS];
  logic signed [ACC_W-1:0]  r_dsk   [COLS][COLS];
  logic signed [ACC_W-1:0]  w_col   [COLS];
  logic signed [ACC_W-1:0]  r_y     [COLS];
  logic [LAT-1:0]   r_v;
  logic             r_yv;
  logic [CNT_W-1:0] r_cnt;
  logic [INF_W-1:0] r_inflt;
  logic             w_adv, w_xfire, w_wfire, w_yfire, w_swap;

  assign y_valid = r_yv;
  assign w_adv   = !r_yv || y_ready;
  assign x_ready = w_adv && (r_state != S_PENDING);
  assign w_xfire = x_valid && x_ready;
  assign w_wfire = w_valid && w_ready;
  assign w_yfire = r_yv && y_ready;

  genvar gk, gc;
  generate
    for (gk = 0; gk < ROWS; gk++) begin : g_xrow
      assign w_x[gk] = x_data[(ROWS-gk)*DATA_W-1 -: DATA_W];
    end
    for (gc = 0; gc < COLS; gc++) begin : g_col
      assign w_wbeat[gc] = w_data[(COLS-gc)*DATA_W-1 -: DATA_W];
      assign y_data[(COLS-gc)*ACC_W-1 -: ACC_W] = r_y[gc];
      // Earlier columns finish sooner; delay them so a vector leaves as one.
      if (gc == COLS-1) begin : g_last
        assign w_col[gc] = r_psum[ROWS-1][gc];
      end else begin : g_dly
        assign w_col[gc] = r_dsk[gc][COLS-2-gc];
      end
    end
    for (gk = 0; gk < ROWS; gk++) begin : g_pe_row
      for (gc = 0; gc < COLS; gc++) begin : g_pe_col
        if (gc == 0) begin : g_ain_edge
          assign w_ain[gk][gc] = r_skew[gk][gk];
        end else begin : g_ain_int
          assign w_ain[gk][gc] = r_act[gk][gc-1];
        end
        if (gk == 0) begin : g_pin_top
          assign w_pin[gk][gc] = '0;
        end else begin : g_pin_int
          assign w_pin[gk][gc] = r_psum[gk-1][gc];
        end
        assign w_prod[gk][gc] = PROD_W'(w_ain[gk][gc]) * PROD_W'(r_wact[gk][gc]);
        assign w_mac[gk][gc]  = w_pin[gk][gc] + ACC_W'(w_prod[gk][gc]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++) begin
        for (int j = 0; j < ROWS; j++) r_skew[k][j] <= '0;
        for (int c = 0; c < COLS; c++) begin
          r_act[k][c]  <= '0;
          r_psum[k][c] <= '0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        for (int j = 0; j < COLS; j++) r_dsk[c][j] <= '0;
        r_y[c] <= '0;
      end
      r_v  <= '0;
      r_yv <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < ROWS; k++) begin
        r_skew[k][0] <= w_x[k];
        for (int j = 1; j < ROWS; j++) r_skew[k][j] <= r_skew[k][j-1];
        for (int c = 0; c < COLS; c++) begin
          r_act[k][c]  <= w_ain[k][c];
          r_psum[k][c] <= w_mac[k][c];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        r_dsk[c][0] <= r_psum[ROWS-1][c];
        for (int j = 1; j < COLS; j++) r_dsk[c][j] <= r_dsk[c][j-1];
        r_y[c] <= w_col[c];
      end
      r_v  <= {r_v[LAT-2:0], w_xfire};
      r_yv <= r_v[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++) begin
        for (int c = 0; c < COLS; c++) begin
          r_wsh[k][c]  <= '0;
          r_wact[k][c] <= '0;
        end
      end
      r_cnt <= '0;
    end else if (w_swap) begin
      r_wact <= r_wsh;
      r_cnt  <= '0;
    end else if (w_wfire) begin
      for (int k = 0; k < ROWS; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          for (int c = 0; c < COLS; c++) r_wsh[k][c] <= w_wbeat[c];
        end
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflt <= '0;
    end else if (w_xfire && !w_yfire) begin
      r_inflt <= r_inflt + INF_W'(1);
    end else if (!w_xfire && w_yfire) begin
      r_inflt <= r_inflt - INF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The bank swap waits for an empty pipeline so no vector mixes weight sets.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) w_state_nxt = (r_cnt == LAST_ROW) ? S_PENDING : S_LOAD;
      end
      S_PENDING: begin
        if (r_inflt == '0) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule
`default_nettype wire
